// File: rtl/eth_rx.sv
// eth_rx -- 10BASE-T Manchester receiver.
//
// Oversamples the raw line and recovers bit timing from mid-bit transitions.
// It strips the preamble/SFD and writes every frame byte, FCS included, into
// a byte-wide BRAM. The FCS is checked as a 32-bit CRC residue. Link pulses
// and the SOI tail never produce a write or a done pulse.
//
// Ports:
//   clk           system clock (CLK_PER_BIT cycles per Manchester bit)
//   rst           synchronous reset, active-high
//   rx_p          raw line input, asynchronous to clk
//   bram_wr_en    one-cycle byte write strobe
//   bram_wr_addr  write address; first byte after the SFD is at 0
//   bram_wr_data  received byte
//   rx_busy       high whenever the receiver is not in IDLE
//   rx_done       one-cycle pulse at the end of a frame that passed preamble
//   rx_len        bytes received including FCS; held until the next rx_done
//   rx_crc_ok     FCS residue correct; held with rx_len
//   rx_err        alignment or overflow error; held with rx_len
module eth_rx #(
    parameter int CLK_PER_BIT = 8,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_p,
    output logic              bram_wr_en,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [7:0]        bram_wr_data,
    output logic              rx_busy,
    output logic              rx_done,
    output logic [ADDR_W:0]   rx_len,
    output logic              rx_crc_ok,
    output logic              rx_err
);

    localparam int T_MID  = 3 * CLK_PER_BIT / 4;
    localparam int T_LOSS = 2 * CLK_PER_BIT;
    localparam int T_W    = $clog2(T_LOSS + 1);
    localparam logic [T_W-1:0]  T_MID_C  = T_W'(T_MID);
    localparam logic [T_W-1:0]  T_LOSS_C = T_W'(T_LOSS);
    localparam logic [31:0]     POLY     = 32'h04C1_1DB7;
    localparam logic [31:0]     RESIDUE  = 32'hC704_DD7B;
    localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_MIN  = (ADDR_W + 1)'(5);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_END
    } state_t;

    state_t state_q, state_d;

    // Line synchronizer and registered edge detector
    logic rx_meta_q, rx_sync_q, rx_last_q;
    logic edge_q, edge_d, level_q, level_d;

    // Timing and framing state
    logic [T_W-1:0]  t_q, t_d;
    logic            prev_bit_q, prev_bit_d;
    logic [3:0]      pre_cnt_q, pre_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0] byte_cnt_q, byte_cnt_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     crc_q, crc_d;

    // Registered outputs
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              crc_ok_q, crc_ok_d;
    logic              err_q, err_d;

    // Carrier loss outranks any edge seen in the same cycle.
    logic loss, accept;
    assign loss   = (t_q >= T_LOSS_C);
    assign accept = edge_q && (t_q >= T_MID_C) && !loss;

    assign edge_d  = rx_sync_q ^ rx_last_q;
    assign level_d = rx_sync_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_WAIT_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_IDLE: if (loss) state_d = S_IDLE;
            S_IDLE:      if (edge_q) state_d = S_PREAMBLE;
            S_PREAMBLE: begin
                if (loss) begin
                    state_d = S_IDLE;
                end else if (accept && (level_q == prev_bit_q)) begin
                    // Repeated bit: "11" after a long enough run is the SFD end,
                    // anything else is a broken preamble.
                    if (level_q && (pre_cnt_q >= 4'd8)) state_d = S_DATA;
                    else                                state_d = S_WAIT_IDLE;
                end
            end
            S_DATA:  if (loss) state_d = S_END;
            S_END:   state_d = S_IDLE;
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        t_d        = t_q;
        prev_bit_d = prev_bit_q;
        pre_cnt_d  = pre_cnt_q;
        byte_d     = byte_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        crc_d      = crc_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // In IDLE any edge is taken as mid-bit; elsewhere only late edges.
        if ((state_q == S_IDLE) ? edge_q : accept) t_d = '0;
        else if (t_q < T_LOSS_C)                   t_d = t_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (edge_q) begin
                    prev_bit_d = level_q;
                    pre_cnt_d  = 4'd0;
                end
            end
            S_PREAMBLE: begin
                byte_cnt_d = '0;
                bit_cnt_d  = 3'd0;
                ovf_d      = 1'b0;
                crc_d      = 32'hFFFF_FFFF;
                if (accept && (level_q != prev_bit_q)) begin
                    prev_bit_d = level_q;
                    if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_d    = {level_q, byte_q[7:1]};
                    crc_d     = (crc_q << 1) ^ ({32{level_q ^ crc_q[31]}} & POLY);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == CAP) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = byte_cnt_q[ADDR_W-1:0];
                            wr_data_d  = {level_q, byte_q[7:1]};
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
        len_d    = len_q;
        crc_ok_d = crc_ok_q;
        err_d    = err_q;
        if (state_q == S_END) begin
            done_d   = 1'b1;
            len_d    = byte_cnt_q;
            err_d    = ovf_q || (bit_cnt_q != 3'd0);
            crc_ok_d = (crc_q == RESIDUE) && (byte_cnt_q >= LEN_MIN)
                       && !(ovf_q || (bit_cnt_q != 3'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b0;
            rx_sync_q  <= 1'b0;
            rx_last_q  <= 1'b0;
            edge_q     <= 1'b0;
            level_q    <= 1'b0;
            t_q        <= '0;
            prev_bit_q <= 1'b0;
            pre_cnt_q  <= 4'd0;
            byte_q     <= 8'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
            crc_q      <= 32'hFFFF_FFFF;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            crc_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_p;
            rx_sync_q  <= rx_meta_q;
            rx_last_q  <= rx_sync_q;
            edge_q     <= edge_d;
            level_q    <= level_d;
            t_q        <= t_d;
            prev_bit_q <= prev_bit_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_q     <= byte_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
            crc_q      <= crc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_q      <= len_d;
            crc_ok_q   <= crc_ok_d;
            err_q      <= err_d;
        end
    end

    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign rx_busy      = busy_q;
    assign rx_done      = done_q;
    assign rx_len       = len_q;
    assign rx_crc_ok    = crc_ok_q;
    assign rx_err       = err_q;

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx -- directed bench for eth_rx.
// A Manchester transmitter model drives rx_p into two receivers: one with the
// default 1 KiB buffer and one with a 16-byte buffer for the overflow case.
// Write strobes and done pulses are logged by a monitor; the main sequence
// checks them against the frame it sent and hand-derived expectations.
`timescale 1ns/1ps
module tb_eth_rx;

    localparam int HALF = 4;  // half of CLK_PER_BIT = 8

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b0;

    logic       wr_en, busy, done, crc_ok, err;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [10:0] len;

    logic       wr_en4, busy4, done4, crc_ok4, err4;
    logic [3:0] wr_addr4;
    logic [7:0] wr_data4;
    logic [4:0] len4;

    always #6.25 clk = ~clk;  // 80 MHz

    eth_rx #(.CLK_PER_BIT(8), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .rx_p(rx_line),
        .bram_wr_en(wr_en), .bram_wr_addr(wr_addr), .bram_wr_data(wr_data),
        .rx_busy(busy), .rx_done(done), .rx_len(len),
        .rx_crc_ok(crc_ok), .rx_err(err)
    );

    eth_rx #(.CLK_PER_BIT(8), .ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .rx_p(rx_line),
        .bram_wr_en(wr_en4), .bram_wr_addr(wr_addr4), .bram_wr_data(wr_data4),
        .rx_busy(busy4), .rx_done(done4), .rx_len(len4),
        .rx_crc_ok(crc_ok4), .rx_err(err4)
    );

    // ---------------- monitor ----------------
    int wr_n = 0, done_n = 0, wr4_n = 0, done4_n = 0;
    logic [9:0] log_addr  [0:1023];
    logic [7:0] log_data  [0:1023];
    logic [3:0] log4_addr [0:1023];

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_n < 1024) begin
                log_addr[wr_n] <= wr_addr;
                log_data[wr_n] <= wr_data;
            end
            wr_n <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
        if (wr_en4) begin
            if (wr4_n < 1024) log4_addr[wr4_n] <= wr_addr4;
            wr4_n <= wr4_n + 1;
        end
        if (done4) done4_n <= done4_n + 1;
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    logic [7:0] frm [0:127];
    int  jit_e  = 0;
    bit  jit_on = 1'b0;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return (c << 1) ^ ({32{b ^ c[31]}} & 32'h04C1_1DB7);
    endfunction

    // npay payload bytes 0,1,2,... followed by the complemented CRC, MSB first.
    task automatic build_frame(input int npay);
        logic [31:0] c;
        logic [7:0]  fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            frm[i] = 8'(i);
            fb = 8'(i);
            for (int j = 0; j < 8; j++) c = crc_step(c, fb[j]);
        end
        for (int k = 0; k < 4; k++) begin
            fb = 8'd0;
            for (int j = 0; j < 8; j++) fb[j] = ~c[31 - (8 * k + j)];
            frm[npay + k] = fb;
        end
    endtask

    task automatic send_bit(input logic b);
        int e;
        e = 0;
        if (jit_on) begin
            // Mid-bit edge wanders by at most one cycle per bit, within +-1.
            e = jit_e + int'($urandom_range(0, 2)) - 1;
            if (e > 1)  e = 1;
            if (e < -1) e = -1;
            jit_e = e;
        end
        rx_line = ~b;
        repeat (HALF + e) @(negedge clk);
        rx_line = b;
        repeat (HALF - e) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int j = 0; j < nbits; j++) send_bit(b[j]);
    endtask

    // Preamble, SFD, nbytes of frm, extra bits of the next byte, SOI tail.
    task automatic send_frame(input int nbytes, input int extra);
        jit_e = 0;
        for (int i = 0; i < 7; i++) send_byte(8'h55, 8);
        send_byte(8'hD5, 8);
        for (int i = 0; i < nbytes; i++) send_byte(frm[i], 8);
        if (extra > 0) send_byte(frm[nbytes], extra);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        rx_line = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int wbase, input int dbase,
                               input int nw, input int len_exp,
                               input logic ok_exp, input logic err_exp);
        chk({tag, "_done"}, 32'(done_n - dbase), 32'd1);
        chk({tag, "_writes"}, 32'(wr_n - wbase), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[wbase + i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), 32'(log_data[wbase + i]), 32'(frm[i]));
        end
        chk({tag, "_len"}, 32'(len), 32'(len_exp));
        chk({tag, "_crc_ok"}, 32'(crc_ok), 32'(ok_exp));
        chk({tag, "_err"}, 32'(err), 32'(err_exp));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        $display("frame %s: writes=%0d len=%0d crc_ok=%0b err=%0b",
                 tag, wr_n - wbase, len, crc_ok, err);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int wb, db, wb4, db4;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(len), 32'd0);
        chk("rst_crc_ok", 32'(crc_ok), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_idle_busy", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("reset: busy=%0b len=%0d", busy, len);

        // 1: good 64-byte frame
        build_frame(60);
        wb = wr_n; db = done_n;
        send_frame(64, 0);
        check_frame("good", wb, db, 64, 64, 1'b1, 1'b0);

        // 2: payload byte 10 bit 3 flipped after FCS computed
        frm[10] = frm[10] ^ 8'h08;
        wb = wr_n; db = done_n;
        send_frame(64, 0);
        check_frame("flip", wb, db, 64, 64, 1'b0, 1'b0);
        chk("flip_byte10", 32'(log_data[wb + 10]), 32'h02);
        frm[10] = 8'd10;

        // 3: link pulses and an idle-high stretch
        wb = wr_n; db = done_n;
        for (int p = 0; p < 3; p++) begin
            rx_line = 1'b1;
            repeat (8) @(negedge clk);
            rx_line = 1'b0;
            repeat (10) @(negedge clk);
            chk($sformatf("nlp%0d_busy", p), 32'(busy), 32'd1);
            repeat (20) @(negedge clk);
            chk($sformatf("nlp%0d_idle", p), 32'(busy), 32'd0);
            repeat (3000) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (200) @(negedge clk);
        rx_line = 1'b0;
        repeat (40) @(negedge clk);
        chk("nlp_writes", 32'(wr_n - wb), 32'd0);
        chk("nlp_done", 32'(done_n - db), 32'd0);
        chk("nlp_busy", 32'(busy), 32'd0);
        $display("link pulses: writes=%0d dones=%0d", wr_n - wb, done_n - db);

        // 4: truncated 3 bits into byte 20
        wb = wr_n; db = done_n;
        send_frame(20, 3);
        check_frame("trunc", wb, db, 20, 20, 1'b0, 1'b1);

        // 5: reset during byte 30, then a clean frame after 10 us idle
        db = done_n;
        fork
            send_frame(64, 0);
            begin
                repeat (64 * 8 + 30 * 64 + 20) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        chk("rstmid_done", 32'(done_n - db), 32'd0);
        repeat (800) @(negedge clk);
        wb = wr_n;
        send_frame(64, 0);
        check_frame("after_rst", wb, db, 64, 64, 1'b1, 1'b0);

        // 6: 20-byte frame into the 16-byte buffer
        build_frame(16);
        wb = wr_n; db = done_n; wb4 = wr4_n; db4 = done4_n;
        send_frame(20, 0);
        check_frame("short", wb, db, 20, 20, 1'b1, 1'b0);
        chk("ovf_done", 32'(done4_n - db4), 32'd1);
        chk("ovf_writes", 32'(wr4_n - wb4), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ovf_addr%0d", i), 32'(log4_addr[wb4 + i]), 32'(i));
        chk("ovf_len", 32'(len4), 32'd16);
        chk("ovf_err", 32'(err4), 32'd1);
        chk("ovf_crc_ok", 32'(crc_ok4), 32'd0);
        $display("frame ovf: writes=%0d len=%0d err=%0b", wr4_n - wb4, len4, err4);

        // 6b: good frame again with edge jitter
        build_frame(60);
        jit_on = 1'b1;
        wb = wr_n; db = done_n;
        send_frame(64, 0);
        jit_on = 1'b0;
        check_frame("jitter", wb, db, 64, 64, 1'b1, 1'b0);

        // Zero-byte frame: carrier loss right after the SFD
        wb = wr_n; db = done_n;
        send_frame(0, 0);
        check_frame("empty", wb, db, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_rx.md
Name: eth_rx

Overview:
- 10BASE-T Manchester receiver. It is the receive-side counterpart of the team's serial Ethernet transmitter.
- Oversamples the raw rx line, recovers bit timing from mid-bit transitions, and strips preamble/SFD.
- Writes frame bytes (including the 4 FCS bytes) into a byte-wide BRAM and checks the FCS.
- Ignores link pulses and the idle tail.
- Downstream logic reads the frame from BRAM after the rx_done pulse.

Parameters:
- CLK_PER_BIT, 8: clk cycles per Manchester bit (8 -> 80 MHz clk for 10 Mb/s). Must be even and >= 8.
- ADDR_W, 10: BRAM byte address width. Capacity is 2**ADDR_W bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_p  in  1  raw line input, asynchronous to clk.
- bram_wr_en  out  1  one-cycle byte write strobe.
- bram_wr_addr  out  ADDR_W  write address; first byte after SFD is at 0.
- bram_wr_data  out  8  received byte.
- rx_busy  out  1  high in any state other than IDLE.
- rx_done  out  1  one-cycle pulse at end of a frame that passed preamble.
- rx_len  out  ADDR_W+1  bytes received including FCS. Valid from rx_done, held until the next rx_done.
- rx_crc_ok  out  1  FCS residue correct. Valid and held with rx_len.
- rx_err  out  1  alignment or overflow error. Valid and held with rx_len.

Behaviour:
Clock, reset and line sampling:
- Single clock and a single synchronous active-high reset are fixed for this block.
- rx_p passes through a 2-flop synchronizer (2 clk latency), then a registered edge detector.
- Reset values: all outputs 0; state WAIT_IDLE; byte and bit counters 0.

Bit encoding:
- A bit's value equals the line level in its second half: a low->high mid-bit transition is 1.
- Bits arrive LSB first.
- Preamble is 0x55 x7, then SFD 0xD5.

Timing counter t:
- Counts clk cycles since the last accepted transition, saturating.
- An edge is accepted as mid-bit when t >= 3*CLK_PER_BIT/4. Bit value = level after the edge; t <= 0.
- Edges with t < 3*CLK_PER_BIT/4 are bit-boundary edges and are ignored.
- Carrier loss: t reaches 2*CLK_PER_BIT with no accepted edge.

State machine:
- WAIT_IDLE: entered on reset or on a preamble error. Go to IDLE on carrier loss. Guarantees a frame cut by reset is never reported.
- IDLE: the first edge of either polarity is taken as mid-bit. t <= 0; go to PREAMBLE; preamble bit count = 0.
- PREAMBLE:
  - Each accepted bit must differ from the previous one; increment the count, saturating at 15.
  - Two consecutive 1s with count >= 8: SFD end, go to DATA.
  - Two consecutive 1s with count < 8, or two consecutive 0s: go to WAIT_IDLE.
  - Carrier loss: go to IDLE, no rx_done. This covers link pulses and the SOI tail.
- DATA:
  - Shift each bit into the byte register LSB first and into the CRC.
  - On every 8th bit, the next cycle drives bram_wr_en=1 with the byte, then increments the address.
  - On carrier loss: go to END.
- END (one cycle): rx_done=1 and outputs latched, then go to IDLE.

CRC:
- 32-bit, poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected.
- Per bit: crc <= (crc<<1) ^ ({32{bit^crc[31]}} & poly).
- Runs over every DATA bit including FCS.
- rx_crc_ok = (crc == 0xC704DD7B) && (rx_len >= 5) && !rx_err.

Boundary cases:
- Partial trailing byte (bit count mod 8 != 0): rx_err=1; partial bits are discarded and not written.
- Overflow: bytes beyond 2**ADDR_W are not written; rx_len saturates at 2**ADDR_W; rx_err=1.
- Zero-byte frame (carrier loss right after SFD): rx_done with rx_len=0, rx_crc_ok=0.
- An edge on the same cycle as carrier-loss detection: carrier loss wins.
- rst asserted mid-frame: no write or done pulse in the following cycle; go to WAIT_IDLE.
- The falling edge of the SOI tail arrives about 3 bit times after the last mid-bit edge. It occurs after END and is handled as a lone edge in PREAMBLE -> IDLE.

Test Plan:
1. Reset, then a 64-byte frame (60 bytes 0x00..0x3B plus correct FCS) from a transmitter model, CLK_PER_BIT=8 -> 64 writes at addrs 0..63 with matching data; one rx_done; rx_len=64, rx_crc_ok=1, rx_err=0.
2. Same frame with payload byte 10 bit 3 flipped -> rx_len=64, rx_crc_ok=0, rx_err=0.
3. Isolated 100 ns high pulses every 16 ms (link pulses), plus line idle high then low -> no bram_wr_en, no rx_done; rx_busy returns low within 2 bit times.
4. Frame truncated 3 bits into byte 20 -> 20 writes, rx_len=20, rx_err=1, rx_crc_ok=0.
5. rst pulsed 1 cycle during byte 30, frame continues, then a second valid frame follows after 10 us idle -> exactly one rx_done; second frame received correctly at addr 0.
6. ADDR_W=4 with a 20-byte frame -> 16 writes (addrs 0..15), rx_len=16, rx_err=1; also check ±12% jitter on edge timing still decodes test 1 correctly.
